umi_gpio_host: RTL and testbench

UMI initiator that drives a remote `umi_gpio` responder. It converts a simple local command port (GPIO write / GPIO read) into UMI request packets on an outbound port, and returns read data from write-response packets on an inbound port. It sits on the host/testbench side of a UMI link, opposite the GPIO responder. It has at most one outstanding request, and reads are protected by a timeout.

---
 rtl/umi_gpio_host.sv | 138 +++++++++++++
 tb/tb_umi_gpio_host.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/umi_gpio_host.sv
// UMI initiator for a remote GPIO responder: local write/read commands become UMI
// requests, read data returns in write-response packets, with a read timeout.
module umi_gpio_host #(
  parameter int          RWIDTH    = 32,
  parameter int          WWIDTH    = 32,
  parameter logic [63:0] GPIO_ADDR = 64'h0,
  parameter logic [63:0] RESP_ADDR = 64'h0,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [WWIDTH-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              resp_valid,
  output logic [RWIDTH-1:0] resp_data,
  output logic              resp_timeout,
  output logic              drop_pulse,
  output logic [255:0]      umi_out_packet,
  output logic              umi_out_valid,
  input  logic              umi_out_ready,
  input  logic [255:0]      umi_in_packet,
  input  logic              umi_in_valid,
  output logic              umi_in_ready
);

  localparam logic [7:0] OP_WR_POSTED = 8'h01;
  localparam logic [7:0] OP_RD_REQ    = 8'h08;
  localparam logic [3:0] WSIZE = 4'($clog2(WWIDTH / 8));
  localparam logic [3:0] RSIZE = 4'($clog2(RWIDTH / 8));
  localparam int DW = 96;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND_WR, SEND_RD, WAIT_RESP} state_t;

  typedef struct packed {
    logic [7:0]    opcode;
    logic [3:0]    size;
    logic [DW-1:0] data;
    logic [63:0]   srcaddr;
  } req_t;

  // Packet layout: 32b command word {burst, user[18:0], size, opcode}, then the low
  // words of dst/src/data, then the high words; the opcode LSB marks a write.
  function automatic logic [255:0] umi_pack(input logic [7:0] opcode, input logic [3:0] size,
                                            input logic [18:0] user, input logic burst,
                                            input logic [63:0] dst, input logic [63:0] src,
                                            input logic [DW-1:0] data);
    return {data[95:32], src[63:32], dst[63:32], data[31:0], src[31:0], dst[31:0],
            burst, user, size, opcode};
  endfunction

  state_t            state, state_nxt;
  req_t              req_q;
  logic [TW-1:0]     timer;
  logic              rsp_fire, rsp_tmo;
  logic [RWIDTH-1:0] rsp_data_nxt;
  logic              resp_valid_q, resp_timeout_q, drop_q;
  logic [RWIDTH-1:0] resp_data_q;
  logic              cmd_hs, out_hs, in_hs, in_write;
  logic [RWIDTH-1:0] in_data;
  logic              unused_in;

  assign cmd_ready     = (state == IDLE) && !rst;
  assign umi_out_valid = ((state == SEND_WR) || (state == SEND_RD)) && !rst;
  assign umi_in_ready  = !rst;

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign out_hs   = umi_out_valid && umi_out_ready;
  assign in_hs    = umi_in_valid && umi_in_ready;
  assign in_write = umi_in_packet[0];
  assign in_data  = RWIDTH'({umi_in_packet[255:192], umi_in_packet[127:96]});
  assign unused_in = ^{umi_in_packet[191:128], umi_in_packet[95:1]};

  assign umi_out_packet = umi_pack(req_q.opcode, req_q.size, 19'h0, 1'b0,
                                   GPIO_ADDR, req_q.srcaddr, req_q.data);

  // Registered pulses are masked so nothing leaks out during the reset cycle.
  assign resp_valid   = resp_valid_q && !rst;
  assign resp_timeout = resp_timeout_q && !rst;
  assign resp_data    = rst ? '0 : resp_data_q;
  assign drop_pulse   = drop_q && !rst;

  always_comb begin
    state_nxt    = state;
    rsp_fire     = 1'b0;
    rsp_tmo      = 1'b0;
    rsp_data_nxt = '0;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = cmd_write ? SEND_WR : SEND_RD;
      SEND_WR: if (out_hs) state_nxt = IDLE;
      SEND_RD: if (out_hs) state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        // A response landing on the expiry cycle takes priority over the timeout.
        if (in_hs && in_write) begin
          rsp_fire     = 1'b1;
          rsp_data_nxt = in_data;
          state_nxt    = IDLE;
        end else if ((TIMEOUT != 0) && (timer == TW'(TIMEOUT))) begin
          rsp_fire  = 1'b1;
          rsp_tmo   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      req_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
      drop_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == SEND_RD && out_hs) timer <= '0;
      else if (state == WAIT_RESP)    timer <= timer + 1'b1;
      if (cmd_hs) begin
        if (cmd_write)
          req_q <= '{opcode: OP_WR_POSTED, size: WSIZE, data: DW'(cmd_wdata), srcaddr: 64'h0};
        else
          req_q <= '{opcode: OP_RD_REQ, size: RSIZE, data: '0, srcaddr: RESP_ADDR};
      end
      resp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        resp_timeout_q <= rsp_tmo;
        resp_data_q    <= rsp_data_nxt;
      end
      drop_q <= in_hs && !(state == WAIT_RESP && in_write);
    end
  end

endmodule

// File: tb/tb_umi_gpio_host.sv
// Directed bench for umi_gpio_host: write, backpressured read, timeout and late drop,
// round trip through a bench-side responder, simultaneous expiry, reset mid-read.
module tb_umi_gpio_host;
  localparam logic [63:0] GA  = 64'hAAAA_0000_0000_1000;
  localparam logic [63:0] RA  = 64'h5555_0000_0000_2000;
  localparam int          TMO = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0]  cmd_wdata = '0;
  logic         cmd_ready, resp_valid, resp_timeout, drop_pulse;
  logic [31:0]  resp_data;
  logic [255:0] umi_out_packet;
  logic         umi_out_valid, umi_in_ready;
  logic         umi_out_ready = 1'b1;
  logic [255:0] umi_in_packet = '0;
  logic         umi_in_valid = 1'b0;

  int n_chk = 0, n_pass = 0;
  int n_out = 0, n_resp = 0;
  int t, base;
  logic [31:0] gpio_in;

  umi_gpio_host #(.RWIDTH(32), .WWIDTH(32), .GPIO_ADDR(GA), .RESP_ADDR(RA), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .drop_pulse(drop_pulse),
    .umi_out_packet(umi_out_packet), .umi_out_valid(umi_out_valid), .umi_out_ready(umi_out_ready),
    .umi_in_packet(umi_in_packet), .umi_in_valid(umi_in_valid), .umi_in_ready(umi_in_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (umi_out_valid && umi_out_ready) n_out++;
    if (resp_valid) n_resp++;
  end

  function automatic logic [255:0] pk(input logic [7:0] op, input logic [63:0] dst,
                                      input logic [63:0] src, input logic [95:0] d);
    return {d[95:32], src[63:32], dst[63:32], d[31:0], src[31:0], dst[31:0],
            1'b0, 19'h0, 4'd2, op};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] d);
    chk("cmd_rdy_pre", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_wdata = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic inject(input logic [255:0] p);
    umi_in_packet = p; umi_in_valid = 1'b1;
    cyc();
    umi_in_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_rdy"}, cmd_ready, 0);
    chk({tag, "_in_rdy"}, umi_in_ready, 0);
    chk({tag, "_out_vld"}, umi_out_valid, 0);
    chk({tag, "_resp_vld"}, resp_valid, 0);
    chk({tag, "_resp_tmo"}, resp_timeout, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_drop"}, drop_pulse, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rdpkt;
    rdpkt = pk(8'h08, GA, RA, 96'h0);
    cyc(); cyc();
    chk_reset_outs("rst");
    rst = 1'b0;
    cyc();
    chk("post_rst_cmd_rdy", cmd_ready, 1);
    chk("post_rst_in_rdy", umi_in_ready, 1);

    // single write, outbound always ready
    issue(1'b1, 32'hDEADBEEF);
    chk("wr_vld", umi_out_valid, 1);
    chk("wr_pkt", umi_out_packet, pk(8'h01, GA, 64'h0, 96'hDEADBEEF));
    chk("wr_busy", cmd_ready, 0);
    cyc();
    chk("wr_vld_off", umi_out_valid, 0);
    chk("wr_cmd_rdy", cmd_ready, 1);
    cyc();
    chk("wr_npkt", n_out, 1);

    // read under 5 cycles of backpressure, then left to time out
    umi_out_ready = 1'b0;
    issue(1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_vld%0d", i), umi_out_valid, 1);
      chk($sformatf("bp_pkt%0d", i), umi_out_packet, rdpkt);
      if (i == 5) umi_out_ready = 1'b1;
      cyc();
    end
    chk("bp_npkt", n_out, 2);
    chk("bp_vld_off", umi_out_valid, 0);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin t = i; break; end
      cyc();
    end
    chk("tmo_lat", t, TMO + 1);
    chk("tmo_flag", resp_timeout, 1);
    chk("tmo_data", resp_data, 0);
    cyc();
    chk("tmo_pulse", resp_valid, 0);
    chk("tmo_cmd_rdy", cmd_ready, 1);
    inject(pk(8'h03, RA, GA, 96'hCAFE0001));
    chk("late_drop", drop_pulse, 1);
    chk("late_nresp", resp_valid, 0);
    cyc();
    chk("late_drop_off", drop_pulse, 0);

    // round trip: bench acts as the GPIO responder, with a stray read request first
    gpio_in = 32'h12345678;
    issue(1'b0, 32'h0);
    chk("rt_vld", umi_out_valid, 1);
    chk("rt_pkt", umi_out_packet, rdpkt);
    cyc();
    inject(pk(8'h08, RA, GA, 96'h0));
    chk("rt_stray_drop", drop_pulse, 1);
    chk("rt_stray_nresp", resp_valid, 0);
    cyc(); cyc();
    inject(pk(8'h03, RA, GA, {64'h0, gpio_in}));
    chk("rt_resp_vld", resp_valid, 1);
    chk("rt_resp_data", resp_data, 32'h12345678);
    chk("rt_resp_tmo", resp_timeout, 0);
    chk("rt_nodrop", drop_pulse, 0);
    cyc();
    chk("rt_pulse", resp_valid, 0);
    chk("rt_cmd_rdy", cmd_ready, 1);

    // response accepted on the expiry cycle wins
    issue(1'b0, 32'h0);
    cyc();
    base = n_resp;
    repeat (TMO) cyc();
    inject(pk(8'h03, RA, GA, 96'hA5A55A5A));
    chk("sim_vld", resp_valid, 1);
    chk("sim_tmo", resp_timeout, 0);
    chk("sim_data", resp_data, 32'hA5A55A5A);
    cyc();
    chk("sim_nresp", n_resp - base, 1);

    // reset while waiting for a read response
    issue(1'b0, 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk_reset_outs("mid");
    rst = 1'b0;
    cyc();
    chk("mid_in_rdy", umi_in_ready, 1);
    chk("mid_cmd_rdy", cmd_ready, 1);
    base = n_resp;
    inject(pk(8'h03, RA, GA, 96'h11112222));
    chk("mid_drop", drop_pulse, 1);
    chk("mid_nresp", resp_valid, 0);
    repeat (TMO + 4) cyc();
    chk("mid_no_resp", n_resp - base, 0);
    base = n_out;
    issue(1'b1, 32'h0BADF00D);
    chk("mid_wr_pkt", umi_out_packet, pk(8'h01, GA, 64'h0, 96'h0BADF00D));
    cyc();
    chk("mid_wr_cmd_rdy", cmd_ready, 1);
    chk("mid_wr_npkt", n_out - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
